// File: rtl/mbist_march_ctrl_pkg.sv
// Shared types and the March C- element table for the MBIST march controller.
// Elements are looked up by index; each one carries its direction, read/write backgrounds and ops.
package mbist_march_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RD   = 3'd2,
        ST_CMP  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // op_mask[1] = element reads each address, op_mask[0] = element writes it
    localparam logic [1:0] OP_W  = 2'b01;
    localparam logic [1:0] OP_R  = 2'b10;
    localparam logic [1:0] OP_RW = 2'b11;

    typedef struct packed {
        logic       dir_up;
        logic       rd_val;
        logic       wr_val;
        logic [1:0] op_mask;
    } elem_t;

    localparam int NUM_ELEM = 6;

    localparam elem_t MC_E0 = '{dir_up: 1'b1, rd_val: 1'b0, wr_val: 1'b0, op_mask: OP_W};
    localparam elem_t MC_E1 = '{dir_up: 1'b1, rd_val: 1'b0, wr_val: 1'b1, op_mask: OP_RW};
    localparam elem_t MC_E2 = '{dir_up: 1'b1, rd_val: 1'b1, wr_val: 1'b0, op_mask: OP_RW};
    localparam elem_t MC_E3 = '{dir_up: 1'b0, rd_val: 1'b0, wr_val: 1'b1, op_mask: OP_RW};
    localparam elem_t MC_E4 = '{dir_up: 1'b0, rd_val: 1'b1, wr_val: 1'b0, op_mask: OP_RW};
    localparam elem_t MC_E5 = '{dir_up: 1'b1, rd_val: 1'b0, wr_val: 1'b0, op_mask: OP_R};

    localparam elem_t [NUM_ELEM-1:0] MARCH_TBL = {MC_E5, MC_E4, MC_E3, MC_E2, MC_E1, MC_E0};

    function automatic elem_t elem_lookup(input logic [2:0] idx);
        elem_t e;
        e = MARCH_TBL[0];
        if (idx < 3'(NUM_ELEM)) begin
            e = MARCH_TBL[idx];
        end
        return e;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_updn_cnt.sv
// Parameterised up/down address counter: load has priority over counting, both gated by cen.
// cout flags the terminal count in the currently selected direction.
module mbist_march_ctrl_updn_cnt #(
    parameter int LENGTH = 10
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              ld,
    input  logic              u_d,
    input  logic [LENGTH-1:0] d_in,
    output logic [LENGTH-1:0] q,
    output logic              cout
);

    always_ff @(posedge clk) begin
        if (cen) begin
            if (ld) begin
                q <= d_in;
            end else if (u_d) begin
                q <= q + LENGTH'(1);
            end else begin
                q <= q - LENGTH'(1);
            end
        end
    end

    assign cout = u_d ? (&q) : ~(|q);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST sequencer: walks six march elements over the address space,
// checks read data against the element background and records the first failing address.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | preset address counter for the current element
// RD    | read strobe at the current address
// CMP   | compare returned data with the expected background
// WR    | write strobe with the element's background
// DONE  | run finished, results held until start or rst
module mbist_march_ctrl
    import mbist_march_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

    elem_t             cur;
    logic              has_rd, has_wr;
    logic              last_addr;
    logic              mismatch;
    state_t            seq_next_state;
    logic [2:0]        seq_next_elem;

    logic              cnt_cen, cnt_ld, cnt_ud, cnt_cout;
    logic [ADDR_W-1:0] cnt_din, cnt_q;

    assign cur       = elem_lookup(elem_q);
    assign has_rd    = cur.op_mask[1];
    assign has_wr    = cur.op_mask[0];
    assign last_addr = cur.dir_up ? (cnt_q == ADDR_LAST) : (cnt_q == '0);
    assign mismatch  = (mem_rdata != {DATA_W{cur.rd_val}});

    mbist_march_ctrl_updn_cnt #(
        .LENGTH (ADDR_W)
    ) u_cnt (
        .clk  (clk),
        .cen  (cnt_cen),
        .ld   (cnt_ld),
        .u_d  (cnt_ud),
        .d_in (cnt_din),
        .q    (cnt_q),
        .cout (cnt_cout)
    );

    // Destination once the current address has finished its per-address ops.
    always_comb begin
        seq_next_state = has_rd ? ST_RD : ST_WR;
        seq_next_elem  = elem_q;
        if (last_addr) begin
            if (elem_q == 3'(NUM_ELEM - 1)) begin
                seq_next_state = ST_DONE;
            end else begin
                seq_next_state = ST_LOAD;
                seq_next_elem  = elem_q + 3'd1;
            end
        end
    end

    always_comb begin
        cnt_cen = 1'b0;
        cnt_ld  = 1'b0;
        cnt_ud  = cur.dir_up;
        cnt_din = '0;
        if (rst) begin
            cnt_cen = 1'b1;
            cnt_ld  = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    cnt_cen = 1'b1;
                    cnt_ld  = 1'b1;
                    cnt_din = cur.dir_up ? '0 : ADDR_LAST;
                end
                ST_WR:   cnt_cen = 1'b1;
                ST_CMP:  cnt_cen = ~has_wr;
                default: cnt_cen = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    elem_d      = 3'd0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                end
            end
            ST_LOAD: state_d = has_rd ? ST_RD : ST_WR;
            ST_RD:   state_d = ST_CMP;
            ST_CMP: begin
                if (mismatch) begin
                    fail_d = 1'b1;
                    if (!fail_q) begin
                        fail_addr_d = cnt_q;
                    end
                end
                if (has_wr) begin
                    state_d = ST_WR;
                end else begin
                    state_d = seq_next_state;
                    elem_d  = seq_next_elem;
                end
            end
            ST_WR: begin
                state_d = seq_next_state;
                elem_d  = seq_next_elem;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    assign busy      = (state_q == ST_LOAD) || (state_q == ST_RD) ||
                       (state_q == ST_CMP)  || (state_q == ST_WR);
    assign done      = (state_q == ST_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign mem_cs    = (state_q == ST_RD) || (state_q == ST_WR);
    assign mem_we    = (state_q == ST_WR);
    assign mem_addr  = cnt_q;
    assign mem_wdata = ((state_q == ST_WR) && cur.wr_val) ? '1 : '0;

    // Terminal count must agree with the compare-based last-address detect inside an element.
    property p_cout_matches_last;
        @(posedge clk) disable iff (rst)
        (state_q inside {ST_RD, ST_CMP, ST_WR}) |-> (cnt_cout == last_addr);
    endproperty
    a_cout_matches_last: assert property (p_cout_matches_last);

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: a small (4-word) instance with fault injection
// and a full-size (1024-word) instance for the long fault-free run.
module tb_mbist_march_ctrl;

    localparam int DW      = 8;
    localparam int AW_S    = 2;
    localparam int DEPTH_S = 4;
    localparam int AW_L    = 10;
    localparam int DEPTH_L = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // small instance
    logic            rst_s, start_s;
    logic            s_busy, s_done, s_fail, s_cs, s_we;
    logic [AW_S-1:0] s_fail_addr, s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [DW-1:0]   ram_s [DEPTH_S];

    // large instance
    logic            rst_l, start_l;
    logic            l_busy, l_done, l_fail, l_cs, l_we;
    logic [AW_L-1:0] l_fail_addr, l_addr;
    logic [DW-1:0]   l_wdata, l_rdata;
    logic [DW-1:0]   ram_l [DEPTH_L];

    mbist_march_ctrl #(.ADDR_W(AW_S), .DATA_W(DW)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .busy(s_busy), .done(s_done),
        .fail(s_fail), .fail_addr(s_fail_addr), .mem_cs(s_cs), .mem_we(s_we),
        .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_rdata(s_rdata)
    );

    mbist_march_ctrl #(.ADDR_W(AW_L), .DATA_W(DW)) dut_l (
        .clk(clk), .rst(rst_l), .start(start_l), .busy(l_busy), .done(l_done),
        .fail(l_fail), .fail_addr(l_fail_addr), .mem_cs(l_cs), .mem_we(l_we),
        .mem_addr(l_addr), .mem_wdata(l_wdata), .mem_rdata(l_rdata)
    );

    // stuck-at fault applied to one bit of one word of the small RAM
    bit f_en = 1'b0;
    int f_addr = 0;
    int f_bit = 0;
    bit f_val = 1'b0;

    function automatic logic [DW-1:0] inj(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (s_cs) begin
            if (s_we) ram_s[s_addr] <= inj(s_wdata, int'(s_addr));
            else      s_rdata <= inj(ram_s[s_addr], int'(s_addr));
        end
    end

    always @(posedge clk) begin
        if (l_cs) begin
            if (l_we) ram_l[l_addr] <= l_wdata;
            else      l_rdata <= ram_l[l_addr];
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // March C- as a list of (direction, read background, write background); -1 = no such op
    int el_up [6] = '{1, 1, 1, 0, 0, 1};
    int el_rd [6] = '{-1, 0, 1, 0, 1, 0};
    int el_wr [6] = '{0, 1, 0, 1, 0, -1};

    typedef struct {
        bit            we;
        int            addr;
        logic [DW-1:0] wd;
    } op_t;
    typedef struct {
        bit fail;
        int faddr;
        int lat;
    } res_t;

    op_t  exp_ops [$];
    res_t exp_res [$];
    logic [DW-1:0] mm [DEPTH_L];

    task automatic model_run(input int depth, input bit push, output bit mfail, output int mfaddr,
                             output int lat, output int nw, output int nr);
        logic [DW-1:0] got, bg;
        int a;
        mfail = 1'b0; mfaddr = 0; lat = 0; nw = 0; nr = 0;
        for (int e = 0; e < 6; e++) begin
            lat++;
            for (int k = 0; k < depth; k++) begin
                a = (el_up[e] != 0) ? k : depth - 1 - k;
                if (el_rd[e] >= 0) begin
                    nr++;
                    lat += 2;
                    got = inj(mm[a], a);
                    bg  = (el_rd[e] != 0) ? '1 : '0;
                    if (got != bg && !mfail) begin
                        mfail  = 1'b1;
                        mfaddr = a;
                    end
                    if (push) exp_ops.push_back('{1'b0, a, '0});
                end
                if (el_wr[e] >= 0) begin
                    nw++;
                    lat++;
                    bg = (el_wr[e] != 0) ? '1 : '0;
                    mm[a] = inj(bg, a);
                    if (push) exp_ops.push_back('{1'b1, a, bg});
                end
            end
        end
    endtask

    // small-instance monitor: pops expected strobes and run results
    int s_t_busy = 0;
    int s_nw = 0;
    int s_nr = 0;
    initial begin
        bit busy_p, done_p;
        op_t  op;
        res_t rs;
        busy_p = 1'b0;
        done_p = 1'b0;
        forever begin
            @(negedge clk);
            if (s_busy && !busy_p) s_t_busy = cyc;
            if (s_cs) begin
                if (s_we) s_nw++; else s_nr++;
                if (exp_ops.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    op = exp_ops.pop_front();
                    chk("op_we", longint'(s_we), longint'(op.we));
                    chk("op_addr", longint'(s_addr), longint'(op.addr));
                    if (op.we) chk("op_wdata", longint'(s_wdata), longint'(op.wd));
                end
            end
            if (s_done && !done_p) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    rs = exp_res.pop_front();
                    chk("run_cycles", longint'(cyc - s_t_busy), longint'(rs.lat));
                    chk("run_fail", longint'(s_fail), longint'(rs.fail));
                    if (rs.fail) chk("run_fail_addr", longint'(s_fail_addr), longint'(rs.faddr));
                    else         chk("run_fail_addr_clr", longint'(s_fail_addr), 0);
                end
            end
            busy_p = s_busy;
            done_p = s_done;
        end
    end

    // large-instance monitor
    int l_t_busy = 0;
    int l_nw = 0;
    int l_nr = 0;
    int l_max = 0;
    initial begin
        bit busy_p;
        busy_p = 1'b0;
        forever begin
            @(negedge clk);
            if (l_busy && !busy_p) l_t_busy = cyc;
            if (l_cs) begin
                if (l_we) l_nw++; else l_nr++;
                if (int'(l_addr) > l_max) l_max = int'(l_addr);
            end
            busy_p = l_busy;
        end
    end

    task automatic run_small(input bit hold, input bit fen, input int fa, input int fb, input bit fv);
        bit mf, seen;
        int mfa, lat, nw, nr;
        f_en = fen; f_addr = fa; f_bit = fb; f_val = fv;
        model_run(DEPTH_S, 1'b1, mf, mfa, lat, nw, nr);
        exp_res.push_back('{mf, mfa, lat});
        s_nw = 0; s_nr = 0;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        chk("load_busy", longint'(s_busy), 1);
        chk("load_done_clr", longint'(s_done), 0);
        chk("load_fail_clr", longint'(s_fail), 0);
        if (!hold) start_s = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (s_done) seen = 1'b1;
        end
        start_s = 1'b0;
        chk("done_seen", longint'(seen), 1);
        @(negedge clk);
        chk("done_hold", longint'(s_done), 1);
        chk("busy_low_in_done", longint'(s_busy), 0);
        chk("ops_left", longint'(exp_ops.size()), 0);
        chk("write_count", longint'(s_nw), longint'(nw));
        chk("read_count", longint'(s_nr), longint'(nr));
        if (!seen) begin
            exp_ops.delete();
            exp_res.delete();
        end
    endtask

    task automatic abort_small();
        bit mf;
        int mfa, lat, nw, nr, k;
        f_en = 1'b0;
        model_run(DEPTH_S, 1'b1, mf, mfa, lat, nw, nr);
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        // busy cycle 0 is LOAD E0; element E2 body spans busy cycles 19..30
        k = 19 + int'($urandom_range(0, 11));
        repeat (k) @(negedge clk);
        rst_s = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        start_s = 1'b0;
        chk("abort_cs", longint'(s_cs), 0);
        chk("abort_busy", longint'(s_busy), 0);
        chk("abort_done", longint'(s_done), 0);
        exp_ops.delete();
        repeat (5) @(negedge clk);
        chk("abort_idle", longint'(s_busy), 0);
    endtask

    task automatic run_large();
        bit mf, seen;
        int mfa, lat, nw, nr, got_lat;
        f_en = 1'b0;
        model_run(DEPTH_L, 1'b0, mf, mfa, lat, nw, nr);
        l_nw = 0; l_nr = 0; l_max = 0;
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        seen = 1'b0;
        got_lat = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (l_done) begin
                seen = 1'b1;
                got_lat = cyc - l_t_busy;
            end
        end
        chk("large_done_seen", longint'(seen), 1);
        chk("large_cycles", longint'(got_lat), longint'(lat));
        chk("large_fail", longint'(l_fail), longint'(mf));
        chk("large_writes", longint'(l_nw), longint'(nw));
        chk("large_reads", longint'(l_nr), longint'(nr));
        chk("large_max_addr", longint'(l_max), longint'(DEPTH_L - 1));
    endtask

    initial begin
        rst_s = 1'b1; start_s = 1'b0;
        rst_l = 1'b1; start_l = 1'b0;
        for (int i = 0; i < DEPTH_S; i++) ram_s[i] = DW'($urandom);
        for (int i = 0; i < DEPTH_L; i++) ram_l[i] = DW'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(s_busy), 0);
        chk("rst_done", longint'(s_done), 0);
        chk("rst_fail", longint'(s_fail), 0);
        chk("rst_fail_addr", longint'(s_fail_addr), 0);
        chk("rst_cs", longint'(s_cs), 0);
        chk("rst_we", longint'(s_we), 0);
        chk("rst_wdata", longint'(s_wdata), 0);
        chk("rst_addr", longint'(s_addr), 0);
        rst_s = 1'b0;

        // rst wins over a simultaneous start
        @(negedge clk);
        rst_s = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        start_s = 1'b0;
        chk("rst_over_start_busy", longint'(s_busy), 0);
        chk("rst_over_start_cs", longint'(s_cs), 0);

        run_small(1'b0, 1'b1, 2, 3, 1'b1);
        run_small(1'b1, 1'b0, 0, 0, 1'b0);
        abort_small();
        run_small(1'b0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom));
        for (int r = 0; r < 6; r++) begin
            run_small(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 7)), 1'($urandom));
        end

        run_large();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
